// File: rtl/fixed_float_conv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fixed_float_conv_seq                                             |
// | Purpose : Multi-cycle converter from fixed point (sign-magnitude or two's  |
// |           complement, INT_BITS.FRAC_BITS) to IEEE-754 single precision.    |
// |           Normalises one bit per cycle, then rounds to nearest-even and    |
// |           flags inexact results. Valid/ready handshakes on both sides.     |
// | Ports   : clk, rst            clock / synchronous active-high reset        |
// |           in_valid/in_ready   input handshake (ready only when idle)       |
// |           in_data [W-1:0]     fixed-point operand, W = 1+INT_BITS+FRAC_BITS|
// |           out_valid/out_ready output handshake (result held until taken)   |
// |           out_data [31:0]     {sign, exp[7:0], mant[22:0]}                 |
// |           out_inexact         discarded bits were nonzero                  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fixed_float_conv_seq #(
  parameter int INT_BITS  = 1,
  parameter int FRAC_BITS = 20,
  parameter int TWOS_COMP = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [INT_BITS+FRAC_BITS:0]     in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [31:0]                     out_data,
  output logic                            out_inexact
);

  localparam int M  = INT_BITS + FRAC_BITS;
  localparam int W  = M + 1;
  // Magnitude bits below the hidden one, padded with 25 zeros so that the
  // mantissa, guard and sticky slices exist even when M < 25.
  localparam int EW = M + 25;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [M:0]  mag_q,   mag_d;
  logic [7:0]  n_q,     n_d;
  logic        sign_q,  sign_d;
  logic [31:0] data_q,  data_d;
  logic        inexact_q, inexact_d;

  // Operand decode: sign and (M+1)-bit magnitude of the incoming word.
  logic        w_in_sign;
  logic [M:0]  w_in_mag;

  if (TWOS_COMP != 0) begin : g_twos_comp
    assign w_in_sign = in_data[W-1];
    // M+1 bits wide so that -2^M negates to 2^M without overflow.
    assign w_in_mag  = in_data[W-1] ? ((~in_data) + W'(1)) : in_data;
  end else begin : g_sign_mag
    assign w_in_sign = in_data[W-1];
    assign w_in_mag  = {1'b0, in_data[M-1:0]};
  end

  // Rounding datapath, evaluated from the normalised magnitude (MSB at bit M).
  logic [EW-1:0] w_ext;
  logic [22:0]   w_mant;
  logic          w_guard;
  logic          w_sticky;
  logic          w_round_up;
  logic [23:0]   w_mant_inc;
  logic [7:0]    w_exp;

  assign w_ext      = {mag_q[M-1:0], 25'd0};
  assign w_mant     = w_ext[EW-1 -: 23];
  assign w_guard    = w_ext[M+1];
  assign w_sticky   = |w_ext[M:0];
  assign w_round_up = w_guard & (w_sticky | w_mant[0]);
  // A carry out of the mantissa leaves bits [22:0] at zero and bumps the exponent.
  assign w_mant_inc = {1'b0, w_mant} + 24'(w_round_up);
  // Exponent arithmetic wraps mod 256; the final value is always in 1..254.
  assign w_exp      = 8'(127 + INT_BITS) - n_q + {7'd0, w_mant_inc[23]};

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    n_d       = n_q;
    sign_d    = sign_q;
    data_d    = data_q;
    inexact_d = inexact_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = w_in_sign;
          mag_d  = w_in_mag;
          n_d    = '0;
          if (w_in_mag == '0) begin
            // Zero (including sign-magnitude -0) always yields +0.
            data_d    = 32'h0000_0000;
            inexact_d = 1'b0;
            state_d   = S_HOLD;
          end else begin
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (mag_q[M]) begin
          state_d = S_ROUND;
        end else begin
          mag_d = mag_q << 1;
          n_d   = n_q + 8'd1;
        end
      end
      S_ROUND: begin
        data_d    = {sign_q, w_exp, w_mant_inc[22:0]};
        inexact_d = w_guard | w_sticky;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      n_q       <= '0;
      sign_q    <= 1'b0;
      data_q    <= 32'h0000_0000;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      n_q       <= n_d;
      sign_q    <= sign_d;
      data_q    <= data_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_HOLD);
  assign out_data    = data_q;
  assign out_inexact = inexact_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_float_conv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fixed_float_conv_seq                                          |
// | Purpose : Self-checking bench for fixed_float_conv_seq. Two instances:     |
// |           A = default 1.20 sign-magnitude, B = 1.30 two's complement.      |
// |           Results are compared against an arithmetic reference model.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fixed_float_conv_seq;

  logic clk = 1'b0;
  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_inexact;
  logic [21:0] a_in_data;
  logic [31:0] a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_inexact;
  logic [31:0] b_in_data;
  logic [31:0] b_out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fixed_float_conv_seq u_dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in_data     (a_in_data),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .out_data    (a_out_data),
    .out_inexact (a_out_inexact)
  );

  fixed_float_conv_seq #(
    .INT_BITS  (1),
    .FRAC_BITS (30),
    .TWOS_COMP (1)
  ) u_dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_data     (b_in_data),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_data    (b_out_data),
    .out_inexact (b_out_inexact)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: value = signed magnitude * 2^-frac, rounded to nearest-even
  // into a 24-bit significand; latency = shifts to normalise + 2.
  function automatic void model(input logic [63:0] raw, input int m, input int frac,
                                input bit tc, output logic [31:0] data,
                                output logic inx, output int lat);
    logic [63:0] mag, q, rem, half;
    logic        sgn;
    int          p, e;
    sgn  = raw[m];
    if (tc) mag = sgn ? ((64'd1 << (m + 1)) - raw) : raw;
    else    mag = raw & ((64'd1 << m) - 64'd1);
    data = 32'h0;
    inx  = 1'b0;
    lat  = 0;
    if (mag == 64'd0) return;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    lat = (m - p) + 2;
    e   = 127 + p - frac;
    if (p > 23) begin
      q    = mag >> (p - 23);
      rem  = mag & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
      inx  = (rem != 64'd0);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end else begin
      q = mag << (23 - p);
    end
    data = {sgn, e[7:0], q[22:0]};
  endfunction

  // One full conversion with out_ready held high: accept, wait, check, hand off.
  task automatic conv(input bit sel, input logic [31:0] d, input string tag);
    logic [31:0] ed;
    logic        ei;
    int          el, cyc;
    if (sel) model({32'd0, d}, 31, 30, 1'b1, ed, ei, el);
    else     model({42'd0, d[21:0]}, 21, 20, 1'b0, ed, ei, el);
    chk({tag, " in_ready"}, sel ? b_in_ready : a_in_ready, 1);
    if (sel) begin b_in_data = d;       b_in_valid = 1'b1; end
    else     begin a_in_data = d[21:0]; a_in_valid = 1'b1; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    cyc = 0;
    while (!(sel ? b_out_valid : a_out_valid) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " latency"}, cyc, el);
    chk({tag, " data"}, sel ? b_out_data : a_out_data, ed);
    chk({tag, " inexact"}, sel ? b_out_inexact : a_out_inexact, ei);
    @(posedge clk); #1;
    chk({tag, " handoff"}, sel ? b_out_valid : a_out_valid, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] r, held;
    logic [20:0] m21;
    int          cyc;

    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", a_in_ready, 1);
    chk("reset out_valid", a_out_valid, 0);
    chk("reset out_data", a_out_data, 32'h0);
    chk("reset out_inexact", a_out_inexact, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed points, default configuration.
    conv(1'b0, 32'h100000, "one");
    conv(1'b0, 32'h280000, "neg_half");
    conv(1'b0, 32'h000001, "lsb");
    conv(1'b0, 32'h000000, "zero");
    conv(1'b0, 32'h200000, "neg_zero");
    conv(1'b0, 32'h3FFFFF, "neg_max");
    // Directed points, two's-complement 1.30 configuration.
    conv(1'b1, 32'h40000040, "tie_even");
    conv(1'b1, 32'h400000C0, "tie_up");
    conv(1'b1, 32'h80000000, "neg_two");
    conv(1'b1, 32'h7FFFFFFF, "round_carry");
    conv(1'b1, 32'hFFFFFFFF, "neg_lsb");
    conv(1'b1, 32'h00000000, "b_zero");

    // Randomised operands across the whole exponent range.
    for (int i = 0; i < 25; i++) begin
      m21 = 21'($urandom()) >> $urandom_range(0, 20);
      conv(1'b0, {10'd0, 1'($urandom_range(0, 1)), m21}, "rand_a");
    end
    for (int i = 0; i < 25; i++) begin
      r = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) r = (r & 32'hFFFFFF80) | 32'h40;
      if ($urandom_range(0, 1) == 1) r = -r;
      conv(1'b1, r, "rand_b");
    end

    // Backpressure: result must hold while out_ready is low, input ignored.
    a_out_ready = 1'b0;
    a_in_data = 22'h100000; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    cyc = 0;
    while (!a_out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp latency", cyc, 3);
    held = 32'h3F800000;
    a_in_data = 22'h080000; a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", a_out_valid, 1);
      chk("bp out_data", a_out_data, held);
      chk("bp in_ready", a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release out_valid", a_out_valid, 0);
    chk("bp release in_ready", a_in_ready, 1);
    chk("bp data persists", a_out_data, held);
    conv(1'b0, 32'h280000, "after_bp");

    // Reset while normalising: in-flight result is dropped.
    a_in_data = 22'h000001; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst in_ready", a_in_ready, 1);
    chk("rst out_valid", a_out_valid, 0);
    chk("rst out_data", a_out_data, 32'h0);
    repeat (25) @(posedge clk);
    #1;
    chk("rst no emit", a_out_valid, 0);
    conv(1'b0, 32'h100000, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
